matmul_result_buffer: RTL and testbench

Result-capture stage directly downstream of the systolic matrix multiplier. When the multiplier raises its finish flag, the block snapshots the flattened result matrix and per-PE overflow flags, then writes them into one of several scratchpad slots. Writes either overwrite the slot or accumulate into it (bias/partial-sum mode). It exposes a registered element-wise read port and a one-cycle `done_o` pulse so control can drop `start`.

---
 rtl/matmul_result_buffer.sv | 158 +++++++++++++++
 tb/tb_matmul_result_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_result_buffer.sv
// Result-capture stage behind the systolic multiplier: snapshots the result matrix on finish,
// then writes or accumulates it element by element into a scratchpad slot with a registered read port.
module matmul_result_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 16,
    parameter int SP_NTARGETS = 4,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int N          = MAX_DIM * MAX_DIM,
    localparam int RW         = 2 * DATA_WIDTH,
    localparam int SW         = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
    localparam int EW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            finish_mul_i,
    input  logic [N*RW-1:0] c_matrix_i,
    input  logic [N-1:0]    flags_i,
    input  logic [SW-1:0]   wr_slot_i,
    input  logic            acc_mode_i,
    input  logic            clear_i,
    input  logic            rd_en_i,
    input  logic [SW-1:0]   rd_slot_i,
    input  logic [EW-1:0]   rd_elem_i,
    output logic [RW-1:0]   rd_data_o,
    output logic            rd_flag_o,
    output logic            rd_valid_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_LOW} state_t;

    state_t          state;
    logic [EW-1:0]   idx;
    logic [N*RW-1:0] cap_data;
    logic [N-1:0]    cap_flags;
    logic [SW-1:0]   cap_slot;
    logic            cap_acc;

    logic [RW-1:0]   data_mem [SP_NTARGETS][N];
    logic [N-1:0]    flag_mem [SP_NTARGETS];

    logic [RW-1:0]   cap_elem;
    logic [RW-1:0]   old_data;
    logic [RW-1:0]   sum;
    logic [RW-1:0]   wr_data;
    logic            old_flag;
    logic            ovf;
    logic            wr_flag;
    logic            wr_en;
    logic            last_elem;
    logic            rd_ok;

    assign busy_o = (state != IDLE);

    // Write datapath: overwrite, or wrapping add with signed-overflow detection.
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cap_elem  = cap_data[int'(idx)*RW +: RW];
        old_data  = data_mem[cap_slot][idx];
        old_flag  = flag_mem[cap_slot][idx];
        sum       = old_data + cap_elem;
        ovf       = (old_data[RW-1] == cap_elem[RW-1]) && (sum[RW-1] != old_data[RW-1]);
        wr_data   = cap_elem;
        wr_flag   = cap_flags[idx];
        if (cap_acc) begin
            wr_data = sum;
            wr_flag = old_flag | cap_flags[idx] | ovf;
        end
        wr_en     = (state == WRITE) && !clear_i && (int'(cap_slot) < SP_NTARGETS);
        last_elem = (idx == EW'(N - 1));
        rd_ok     = (int'(rd_slot_i) < SP_NTARGETS) && (int'(rd_elem_i) < N);
    end

    // NOTE: the scratchpad is reset and cleared as plain registers because its contents are
    // architecturally visible as zero after reset; a RAM macro could not provide that.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SP_NTARGETS; s++) begin
                flag_mem[s] <= '0;
                for (int e = 0; e < N; e++) data_mem[s][e] <= '0;
            end
        end else if (clear_i) begin
            for (int s = 0; s < SP_NTARGETS; s++) begin
                flag_mem[s] <= '0;
                for (int e = 0; e < N; e++) data_mem[s][e] <= '0;
            end
        end else if (wr_en) begin
            data_mem[cap_slot][idx] <= wr_data;
            flag_mem[cap_slot][idx] <= wr_flag;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            idx       <= '0;
            cap_data  <= '0;
            cap_flags <= '0;
            cap_slot  <= '0;
            cap_acc   <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (finish_mul_i) begin
                        cap_data  <= c_matrix_i;
                        cap_flags <= flags_i;
                        cap_slot  <= wr_slot_i;
                        cap_acc   <= acc_mode_i;
                        idx       <= '0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    // A clear aborts the capture silently; finish must still drop before re-arming.
                    if (clear_i) begin
                        idx   <= '0;
                        state <= WAIT_LOW;
                    end else if (last_elem) begin
                        idx    <= '0;
                        done_o <= 1'b1;
                        state  <= WAIT_LOW;
                    end else begin
                        idx <= idx + EW'(1);
                    end
                end
                WAIT_LOW: begin
                    if (!finish_mul_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read port samples the memory before any same-edge write lands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_o  <= '0;
            rd_flag_o  <= 1'b0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                if (rd_ok) begin
                    rd_data_o <= data_mem[rd_slot_i][rd_elem_i];
                    rd_flag_o <= flag_mem[rd_slot_i][rd_elem_i];
                end else begin
                    rd_data_o <= '0;
                    rd_flag_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_result_buffer.sv
// Bench for matmul_result_buffer: directed scenarios plus random captures checked against
// an integer-arithmetic scratchpad model.
module tb_matmul_result_buffer;

    localparam int N  = 4;
    localparam int NS = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        finish_mul_i;
    logic [63:0] c_matrix_i;
    logic [3:0]  flags_i;
    logic [1:0]  wr_slot_i;
    logic        acc_mode_i;
    logic        clear_i;
    logic        rd_en_i;
    logic [1:0]  rd_slot_i;
    logic [1:0]  rd_elem_i;
    logic [15:0] rd_data_o;
    logic        rd_flag_o;
    logic        rd_valid_o;
    logic        busy_o;
    logic        done_o;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_data [NS][N];
    logic        model_flag [NS][N];
    logic [15:0] nxt_d [N];
    logic        nxt_f [N];

    matmul_result_buffer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .finish_mul_i (finish_mul_i),
        .c_matrix_i   (c_matrix_i),
        .flags_i      (flags_i),
        .wr_slot_i    (wr_slot_i),
        .acc_mode_i   (acc_mode_i),
        .clear_i      (clear_i),
        .rd_en_i      (rd_en_i),
        .rd_slot_i    (rd_slot_i),
        .rd_elem_i    (rd_elem_i),
        .rd_data_o    (rd_data_o),
        .rd_flag_o    (rd_flag_o),
        .rd_valid_o   (rd_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++)
            for (int e = 0; e < N; e++) begin
                model_data[s][e] = '0;
                model_flag[s][e] = 1'b0;
            end
    endtask

    // Next slot contents from signed integer arithmetic: overflow means the true sum leaves 16-bit range.
    task automatic model_compute(input int slot, input bit acc, input logic [63:0] c, input logic [3:0] fl);
        for (int e = 0; e < N; e++) begin
            logic [15:0] b;
            int a, bi, s;
            b  = c[e*16 +: 16];
            a  = $signed(model_data[slot][e]);
            bi = $signed(b);
            s  = a + bi;
            if (acc) begin
                nxt_d[e] = s[15:0];
                nxt_f[e] = model_flag[slot][e] | fl[e] | ((s > 32767) || (s < -32768));
            end else begin
                nxt_d[e] = b;
                nxt_f[e] = fl[e];
            end
        end
    endtask

    task automatic model_commit(input int slot);
        for (int e = 0; e < N; e++) begin
            model_data[slot][e] = nxt_d[e];
            model_flag[slot][e] = nxt_f[e];
        end
    endtask

    task automatic read_check(input int slot, input int elem, input string tag);
        string t;
        t = $sformatf("%s_s%0d_e%0d", tag, slot, elem);
        rd_en_i   = 1'b1;
        rd_slot_i = 2'(slot);
        rd_elem_i = 2'(elem);
        @(negedge clk_i);
        rd_en_i = 1'b0;
        check({t, "_valid"}, rd_valid_o, 1);
        check({t, "_data"}, rd_data_o, model_data[slot][elem]);
        check({t, "_flag"}, rd_flag_o, model_flag[slot][elem]);
    endtask

    task automatic check_all(input string tag);
        for (int s = 0; s < NS; s++)
            for (int e = 0; e < N; e++) read_check(s, e, tag);
    endtask

    // One capture; finish stays high for 'hold' extra cycles. col_elem >= 0 issues two reads of that
    // element in slot 'slot', the first on the very edge that writes it.
    task automatic run_capture(input int slot, input bit acc, input logic [63:0] c, input logic [3:0] fl,
                               input int hold, input int col_elem, input string tag);
        int w, done_cnt, done_at;
        logic [15:0] old_d;
        logic        old_f;
        w = 0;
        while (busy_o === 1'b1 && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        check({tag, "_idle"}, busy_o, 0);
        model_compute(slot, acc, c, fl);
        old_d = '0;
        old_f = 1'b0;
        if (col_elem >= 0) begin
            old_d = model_data[slot][col_elem];
            old_f = model_flag[slot][col_elem];
        end
        wr_slot_i    = 2'(slot);
        acc_mode_i   = acc;
        c_matrix_i   = c;
        flags_i      = fl;
        finish_mul_i = 1'b1;
        done_cnt = 0;
        done_at  = -1;
        for (int k = 1; k <= 5 + hold; k++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 1) begin
                wr_slot_i  = 2'($urandom);
                acc_mode_i = 1'($urandom);
                c_matrix_i = {$urandom, $urandom};
                flags_i    = 4'($urandom);
            end
            if (col_elem >= 0) begin
                if (k == col_elem + 1) begin
                    rd_en_i   = 1'b1;
                    rd_slot_i = 2'(slot);
                    rd_elem_i = 2'(col_elem);
                end else if (k == col_elem + 2) begin
                    check({tag, "_col_valid"}, rd_valid_o, 1);
                    check({tag, "_col_old"}, rd_data_o, old_d);
                    check({tag, "_col_oldflag"}, rd_flag_o, old_f);
                end else if (k == col_elem + 3) begin
                    rd_en_i = 1'b0;
                    check({tag, "_col2_valid"}, rd_valid_o, 1);
                    check({tag, "_col2_new"}, rd_data_o, nxt_d[col_elem]);
                    check({tag, "_col2_newflag"}, rd_flag_o, nxt_f[col_elem]);
                end else if (k == col_elem + 4) begin
                    check({tag, "_col_novalid"}, rd_valid_o, 0);
                    check({tag, "_col_hold"}, rd_data_o, nxt_d[col_elem]);
                end
            end
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_at"}, done_at, 5);
        check({tag, "_busy_held"}, busy_o, 1);
        finish_mul_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_busy_low"}, busy_o, 0);
        check({tag, "_done_low"}, done_o, 0);
        model_commit(slot);
    endtask

    initial begin
        int done_seen;
        finish_mul_i = 1'b0;
        c_matrix_i   = '0;
        flags_i      = '0;
        wr_slot_i    = '0;
        acc_mode_i   = 1'b0;
        clear_i      = 1'b0;
        rd_en_i      = 1'b0;
        rd_slot_i    = '0;
        rd_elem_i    = '0;
        rst_ni       = 1'b1;
        model_clear();
        #2 rst_ni = 1'b0;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_valid", rd_valid_o, 0);
        check("rst_data", rd_data_o, 0);
        check("rst_flag", rd_flag_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all("init");

        // Overwrite capture with sign-boundary values.
        run_capture(1, 1'b0, {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001}, 4'b0010, 0, -1, "ovw");
        check_all("ovw");

        // Accumulate into the same slot: wrap, overflow both ways, sticky flag.
        run_capture(1, 1'b1, {16'hFFFF, 16'h0001, 16'h0001, 16'h0001}, 4'b0000, 0, -1, "acc");
        check_all("acc");

        // Finish held high: one capture only, then a second after finish drops and re-rises.
        run_capture(2, 1'b0, {$urandom, $urandom}, 4'($urandom), 20, -1, "hold");
        run_capture(2, 1'b1, {$urandom, $urandom}, 4'($urandom), 0, -1, "rerise");
        check_all("hold");

        // Read of the element being written on that same edge.
        run_capture(2, 1'b0, {$urandom, $urandom}, 4'($urandom), 0, 1, "col");

        for (int i = 0; i < 8; i++)
            run_capture(int'($urandom_range(3, 0)), 1'($urandom), {$urandom, $urandom}, 4'($urandom),
                        0, -1, $sformatf("rnd%0d", i));
        check_all("rnd");

        // Asynchronous reset in the middle of a capture.
        wr_slot_i    = 2'd3;
        acc_mode_i   = 1'b0;
        c_matrix_i   = {$urandom, $urandom};
        flags_i      = 4'hF;
        finish_mul_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rd_en_i   = 1'b1;
        rd_slot_i = 2'd1;
        rd_elem_i = 2'd0;
        @(negedge clk_i);
        rd_en_i = 1'b0;
        check("midrst_pre_busy", busy_o, 1);
        check("midrst_pre_valid", rd_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_valid", rd_valid_o, 0);
        check("midrst_data", rd_data_o, 0);
        finish_mul_i = 1'b0;
        model_clear();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all("midrst");
        run_capture(3, 1'b1, {$urandom, $urandom}, 4'($urandom), 0, -1, "post_rst");
        run_capture(0, 1'b0, {$urandom, $urandom}, 4'($urandom), 0, -1, "post_rst2");
        check_all("post_rst");

        // Synchronous clear on the edge that writes element 1.
        wr_slot_i    = 2'd0;
        acc_mode_i   = 1'b1;
        c_matrix_i   = {$urandom, $urandom};
        flags_i      = 4'($urandom);
        finish_mul_i = 1'b1;
        done_seen    = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) done_seen++;
            if (k == 2) clear_i = 1'b1;
            if (k == 3) clear_i = 1'b0;
        end
        check("clr_no_done", done_seen, 0);
        check("clr_busy_wait", busy_o, 1);
        finish_mul_i = 1'b0;
        @(negedge clk_i);
        check("clr_idle", busy_o, 0);
        model_clear();
        check_all("clr");
        run_capture(0, 1'b1, {$urandom, $urandom}, 4'($urandom), 0, -1, "post_clr");
        check_all("post_clr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
